dmac_mc_master: RTL and testbench

DMAC_MC_MASTER -- requirements
Module: dmac_mc_master

---
 rtl/dmac_pkg.sv | 46 ++++
 rtl/dmac_mc_master_if.sv | 20 ++
 rtl/dmac_rr_arb.sv | 43 ++++
 rtl/dmac_mc_master.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dmac_mc_master.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmac_pkg.sv
// Shared state encoding, AHB constants and the read-lane extraction helper
// for the multi-channel DMA master.
package dmac_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_WFI,
        ST_RD_A,
        ST_RD_D,
        ST_WR_A,
        ST_WR_D,
        ST_NEXT,
        ST_ICR_A,
        ST_ICR_D
    } dmac_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Picks the addressed byte/halfword out of a little-endian word and
    // replicates it across all 32 bits so any destination lane sees it.
    function automatic logic [31:0] lane_extract(input logic [31:0] data,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  size);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = off[1] ? data[31:16] : data[15:0];
        case (size)
            HSIZE_BYTE: lane_extract = {4{b}};
            HSIZE_HALF: lane_extract = {2{h}};
            default:    lane_extract = data;
        endcase
    endfunction

endpackage

// File: rtl/dmac_mc_master_if.sv
// AHB-Lite master/slave bundle used between the DMA master and its bus.
interface dmac_mc_master_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;

    modport master (
        output HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        input  HREADY, HRDATA
    );

    modport slave (
        input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        output HREADY, HRDATA
    );
endinterface

// File: rtl/dmac_rr_arb.sv
// Round-robin arbiter: search starts one past the last grant; the pointer
// moves only when enabled and some request is present.
module dmac_rr_arb #(
    parameter int NCH = 4,
    parameter int IW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           en,
    output logic [NCH-1:0] grant,
    output logic [IW-1:0]  grant_idx
);

    logic [IW-1:0] ptr;
    int            idx;
    logic          found;

    // NOTE: every variable gets a default before the search loop so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(ptr) + k) % NCH;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IW'(NCH - 1);
        end else if (en && |req) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/dmac_mc_master.sv
// Multi-channel AHB-Lite DMA master: one shared bus engine, round-robin per block.
// Define DMAC_MC_ICR_EN to add the interrupt-clear write ahead of each requested beat.
module dmac_mc_master
    import dmac_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic                HCLK,
    input  logic                HRESET,
    dmac_mc_master_if.master    bus,
    input  logic [32*NCH-1:0]   saddr,
    input  logic [32*NCH-1:0]   daddr,
    input  logic [3*NCH-1:0]    ssize,
    input  logic [3*NCH-1:0]    dsize,
    input  logic [3*NCH-1:0]    sinc,
    input  logic [3*NCH-1:0]    dinc,
    input  logic [CW*NCH-1:0]   bsize,
    input  logic [CW*NCH-1:0]   bcount,
    input  logic [NCH-1:0]      start,
    input  logic [NCH-1:0]      wfi,
    input  logic [3*NCH-1:0]    irqsrc,
    input  logic [7:0]          pirq,
`ifdef DMAC_MC_ICR_EN
    input  logic [32*NCH-1:0]   icra,
    input  logic [32*NCH-1:0]   icrv,
`endif
    output logic [NCH-1:0]      done,
    output logic [NCH-1:0]      busy
);

    localparam int IW = $clog2(NCH);

    logic [31:0]   saddr_a [NCH];
    logic [31:0]   daddr_a [NCH];
    logic [2:0]    ssize_a [NCH];
    logic [2:0]    dsize_a [NCH];
    logic [2:0]    sinc_a  [NCH];
    logic [2:0]    dinc_a  [NCH];
    logic [2:0]    irq_a   [NCH];
    logic [CW-1:0] bsize_a [NCH];
    logic [CW-1:0] bcount_a[NCH];
`ifdef DMAC_MC_ICR_EN
    logic [31:0]   icra_a  [NCH];
    logic [31:0]   icrv_a  [NCH];
`endif

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            saddr_a[i]  = saddr[32*i +: 32];
            daddr_a[i]  = daddr[32*i +: 32];
            ssize_a[i]  = ssize[3*i +: 3];
            dsize_a[i]  = dsize[3*i +: 3];
            sinc_a[i]   = sinc[3*i +: 3];
            dinc_a[i]   = dinc[3*i +: 3];
            irq_a[i]    = irqsrc[3*i +: 3];
            bsize_a[i]  = bsize[CW*i +: CW];
            bcount_a[i] = bcount[CW*i +: CW];
`ifdef DMAC_MC_ICR_EN
            icra_a[i]   = icra[32*i +: 32];
            icrv_a[i]   = icrv[32*i +: 32];
`endif
        end
    end

    // Per-channel working copies; sa/da and the two counters advance as beats complete.
    logic [31:0]   sa  [NCH];
    logic [31:0]   da  [NCH];
    logic [2:0]    ss  [NCH];
    logic [2:0]    ds  [NCH];
    logic [2:0]    si  [NCH];
    logic [2:0]    di  [NCH];
    logic [CW-1:0] bs  [NCH];
    logic [CW-1:0] beat[NCH];
    logic [CW-1:0] blk [NCH];

    dmac_state_e    state;
    logic [IW-1:0]  cur;
    logic [NCH-1:0] cur_mask;
    logic [31:0]    data_reg;

    logic [NCH-1:0] grant;
    logic [IW-1:0]  grant_idx;

    dmac_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
        .clk       (HCLK),
        .rst       (HRESET),
        .req       (busy),
        .en        (state == ST_ARB),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // NOTE: all state here is written with <= so every branch sees pre-edge values.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= ST_IDLE;
            cur         <= '0;
            cur_mask    <= '0;
            data_reg    <= '0;
            busy        <= '0;
            done        <= '0;
            bus.HTRANS  <= HTRANS_IDLE;
            bus.HADDR   <= '0;
            bus.HSIZE   <= HSIZE_WORD;
            bus.HWRITE  <= 1'b0;
            bus.HWDATA  <= '0;
            // NOTE: the per-channel arrays are small register files acting as counters, so they are reset too.
            for (int i = 0; i < NCH; i++) begin
                sa[i]   <= '0;
                da[i]   <= '0;
                ss[i]   <= '0;
                ds[i]   <= '0;
                si[i]   <= '0;
                di[i]   <= '0;
                bs[i]   <= '0;
                beat[i] <= '0;
                blk[i]  <= '0;
            end
        end else begin
            done       <= '0;
            bus.HTRANS <= HTRANS_IDLE;
            bus.HADDR  <= '0;
            bus.HSIZE  <= HSIZE_WORD;
            bus.HWRITE <= 1'b0;

            for (int i = 0; i < NCH; i++) begin
                if (start[i] && !busy[i]) begin
                    sa[i]   <= saddr_a[i];
                    da[i]   <= daddr_a[i];
                    ss[i]   <= ssize_a[i];
                    ds[i]   <= dsize_a[i];
                    si[i]   <= sinc_a[i];
                    di[i]   <= dinc_a[i];
                    bs[i]   <= bsize_a[i];
                    beat[i] <= bsize_a[i];
                    blk[i]  <= bcount_a[i];
                    if (bsize_a[i] == '0 || bcount_a[i] == '0) begin
                        done[i] <= 1'b1;
                    end else begin
                        busy[i] <= 1'b1;
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (|busy) state <= ST_ARB;
                end

                ST_ARB: begin
                    if (|busy) begin
                        cur      <= grant_idx;
                        cur_mask <= grant;
                        state    <= ST_WFI;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_WFI: begin
                    if (!wfi[cur] || pirq[irq_a[cur]]) begin
`ifdef DMAC_MC_ICR_EN
                        if (wfi[cur]) begin
                            state      <= ST_ICR_A;
                            bus.HTRANS <= HTRANS_NONSEQ;
                            bus.HADDR  <= icra_a[cur];
                            bus.HWRITE <= 1'b1;
                        end else begin
                            state      <= ST_RD_A;
                            bus.HTRANS <= HTRANS_NONSEQ;
                            bus.HADDR  <= sa[cur];
                            bus.HSIZE  <= ss[cur];
                        end
`else
                        state      <= ST_RD_A;
                        bus.HTRANS <= HTRANS_NONSEQ;
                        bus.HADDR  <= sa[cur];
                        bus.HSIZE  <= ss[cur];
`endif
                    end else if (|(busy & ~cur_mask)) begin
                        state <= ST_ARB;
                    end
                end

                // Address phases hold every bus output until the slave accepts.
                ST_RD_A, ST_WR_A, ST_ICR_A: begin
                    if (bus.HREADY) begin
                        case (state)
                            ST_RD_A: state <= ST_RD_D;
                            ST_WR_A: begin
                                state      <= ST_WR_D;
                                bus.HWDATA <= data_reg;
                            end
                            default: begin
                                state <= ST_ICR_D;
`ifdef DMAC_MC_ICR_EN
                                bus.HWDATA <= icrv_a[cur];
`endif
                            end
                        endcase
                    end else begin
                        bus.HTRANS <= bus.HTRANS;
                        bus.HADDR  <= bus.HADDR;
                        bus.HSIZE  <= bus.HSIZE;
                        bus.HWRITE <= bus.HWRITE;
                    end
                end

                ST_RD_D: begin
                    if (bus.HREADY) begin
                        data_reg   <= lane_extract(bus.HRDATA, sa[cur][1:0], ss[cur]);
                        sa[cur]    <= sa[cur] + 32'(si[cur]);
                        state      <= ST_WR_A;
                        bus.HTRANS <= HTRANS_NONSEQ;
                        bus.HADDR  <= da[cur];
                        bus.HSIZE  <= ds[cur];
                        bus.HWRITE <= 1'b1;
                    end
                end

                ST_WR_D: begin
                    if (bus.HREADY) begin
                        da[cur] <= da[cur] + 32'(di[cur]);
                        state   <= ST_NEXT;
                    end
                end

                ST_ICR_D: begin
                    if (bus.HREADY) begin
                        state      <= ST_RD_A;
                        bus.HTRANS <= HTRANS_NONSEQ;
                        bus.HADDR  <= sa[cur];
                        bus.HSIZE  <= ss[cur];
                    end
                end

                ST_NEXT: begin
                    if (beat[cur] != CW'(1)) begin
                        beat[cur] <= beat[cur] - CW'(1);
                        state     <= ST_WFI;
                    end else if (blk[cur] != CW'(1)) begin
                        blk[cur]  <= blk[cur] - CW'(1);
                        beat[cur] <= bs[cur];
                        state     <= ST_ARB;
                    end else begin
                        beat[cur] <= '0;
                        blk[cur]  <= '0;
                        done[cur] <= 1'b1;
                        busy[cur] <= 1'b0;
                        state     <= (|(busy & ~cur_mask)) ? ST_ARB : ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmac_mc_master.sv
// Scoreboard bench for dmac_mc_master: expected bus transactions are queued
// when a channel is configured and popped as the AHB slave model accepts them.
module tb_dmac_mc_master;
    import dmac_pkg::*;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic                HCLK = 1'b0;
    logic                HRESET = 1'b1;
    logic [32*NCH-1:0]   saddr = '0, daddr = '0;
    logic [3*NCH-1:0]    ssize = '0, dsize = '0, sinc = '0, dinc = '0, irqsrc = '0;
    logic [CW*NCH-1:0]   bsize = '0, bcount = '0;
    logic [NCH-1:0]      start = '0, wfi = '0;
    logic [7:0]          pirq = '0;
    logic [NCH-1:0]      done, busy;
`ifdef DMAC_MC_ICR_EN
    logic [32*NCH-1:0]   icra = '0, icrv = '0;
`endif

    dmac_mc_master_if bus();

    dmac_mc_master #(.NCH(NCH), .CW(CW)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus.master),
        .saddr  (saddr),
        .daddr  (daddr),
        .ssize  (ssize),
        .dsize  (dsize),
        .sinc   (sinc),
        .dinc   (dinc),
        .bsize  (bsize),
        .bcount (bcount),
        .start  (start),
        .wfi    (wfi),
        .irqsrc (irqsrc),
        .pirq   (pirq),
`ifdef DMAC_MC_ICR_EN
        .icra   (icra),
        .icrv   (icrv),
`endif
        .done   (done),
        .busy   (busy)
    );

    initial forever #5 HCLK = ~HCLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Slave memory contents: one distinctive word, otherwise address-derived.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a[31:2] == 30'h40) return 32'hAABB_CCDD;
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] tb_extract(input logic [31:0] d, input logic [1:0] off,
                                               input logic [2:0] size);
        logic [31:0] b, h;
        b = (d >> (8 * off)) & 32'hFF;
        h = (d >> (16 * off[1])) & 32'hFFFF;
        if (size == 3'd0) return b * 32'h0101_0101;
        if (size == 3'd1) return h * 32'h0001_0001;
        return d;
    endfunction

    // Per-channel reference address model.
    logic [31:0] m_sa[NCH], m_da[NCH], m_icra[NCH], m_icrv[NCH];
    logic [2:0]  m_ss[NCH], m_ds[NCH], m_si[NCH], m_di[NCH];
    logic        m_wfi[NCH];

    task automatic cfg(input int ch, input logic [31:0] sa, input logic [31:0] da,
                       input logic [2:0] ss, input logic [2:0] ds, input logic [2:0] si,
                       input logic [2:0] di, input int bs, input int bc, input logic wf,
                       input logic [2:0] irq);
        saddr[32*ch +: 32]  = sa;
        daddr[32*ch +: 32]  = da;
        ssize[3*ch +: 3]    = ss;
        dsize[3*ch +: 3]    = ds;
        sinc[3*ch +: 3]     = si;
        dinc[3*ch +: 3]     = di;
        bsize[CW*ch +: CW]  = CW'(bs);
        bcount[CW*ch +: CW] = CW'(bc);
        wfi[ch]             = wf;
        irqsrc[3*ch +: 3]   = irq;
        m_sa[ch] = sa;  m_da[ch] = da;  m_ss[ch] = ss;  m_ds[ch] = ds;
        m_si[ch] = si;  m_di[ch] = di;  m_wfi[ch] = wf;
        m_icra[ch] = 32'h9000_0000 + 32'(ch * 16);
        m_icrv[ch] = 32'h0000_5A00 + 32'(ch);
`ifdef DMAC_MC_ICR_EN
        icra[32*ch +: 32] = m_icra[ch];
        icrv[32*ch +: 32] = m_icrv[ch];
`endif
    endtask

    task automatic push_block(input int ch, input int nbeats);
        txn_t t;
        for (int b = 0; b < nbeats; b++) begin
`ifdef DMAC_MC_ICR_EN
            if (m_wfi[ch]) begin
                t = '{wr: 1'b1, addr: m_icra[ch], size: HSIZE_WORD, data: m_icrv[ch]};
                exp_q.push_back(t);
            end
`endif
            t = '{wr: 1'b0, addr: m_sa[ch], size: m_ss[ch], data: 32'h0};
            exp_q.push_back(t);
            t = '{wr: 1'b1, addr: m_da[ch], size: m_ds[ch],
                  data: tb_extract(mem_rd(m_sa[ch]), m_sa[ch][1:0], m_ss[ch])};
            exp_q.push_back(t);
            m_sa[ch] = m_sa[ch] + 32'(m_si[ch]);
            m_da[ch] = m_da[ch] + 32'(m_di[ch]);
        end
    endtask

    // Slave/monitor state.
    logic        data_pend = 1'b0, pend_wr = 1'b0, wr_d_seen = 1'b0;
    logic [31:0] pend_data = '0, stall_addr = '0;
    logic [1:0]  stall_tr = '0;
    logic        stall_en = 1'b0, stalled = 1'b0;
    int          stall_left = 0, stall_hits = 0, act_cnt = 0;
    int          done_cnt[NCH];

    initial begin
        txn_t e;
        bus.HREADY = 1'b1;
        bus.HRDATA = '0;
        for (int i = 0; i < NCH; i++) done_cnt[i] = 0;
        forever begin
            @(negedge HCLK);
            wr_d_seen = data_pend && pend_wr;
            if (bus.HTRANS != HTRANS_IDLE) act_cnt++;
            for (int i = 0; i < NCH; i++) if (done[i]) done_cnt[i]++;
            if (HRESET) begin
                data_pend  = 1'b0;
                stalled    = 1'b0;
                stall_left = 0;
                bus.HREADY = 1'b1;
            end else begin
                if (stall_en && !stalled && stall_left == 0 &&
                    ((data_pend && !pend_wr) ||
                     (!data_pend && bus.HTRANS == HTRANS_NONSEQ && bus.HWRITE))) begin
                    stall_left = 3;
                    stalled    = 1'b1;
                    stall_hits++;
                    stall_addr = bus.HADDR;
                    stall_tr   = bus.HTRANS;
                end
                if (stall_left > 0) begin
                    bus.HREADY = 1'b0;
                    stall_left--;
                    check("stall_htrans", 64'(bus.HTRANS), 64'(stall_tr));
                    check("stall_haddr", 64'(bus.HADDR), 64'(stall_addr));
                end else begin
                    bus.HREADY = 1'b1;
                    if (data_pend) begin
                        if (pend_wr) check("hwdata", 64'(bus.HWDATA), 64'(pend_data));
                        data_pend = 1'b0;
                        stalled   = 1'b0;
                    end else if (bus.HTRANS == HTRANS_NONSEQ) begin
                        if (exp_q.size() == 0) begin
                            check("spurious_txn", 64'(exp_q.size()), 64'd1);
                        end else begin
                            e = exp_q.pop_front();
                            check("haddr", 64'(bus.HADDR), 64'(e.addr));
                            check("hwrite", 64'(bus.HWRITE), 64'(e.wr));
                            check("hsize", 64'(bus.HSIZE), 64'(e.size));
                            pend_wr   = e.wr;
                            pend_data = e.data;
                        end
                        data_pend = 1'b1;
                        stalled   = 1'b0;
                        if (!bus.HWRITE) bus.HRDATA = mem_rd(bus.HADDR);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge HCLK);
        #1;
    endtask

    task automatic pulse_start(input logic [NCH-1:0] mask);
        start = mask;
        tick();
        start = '0;
    endtask

    task automatic wait_done(input int ch, input int target, input int budget);
        int n = 0;
        while (done_cnt[ch] < target && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("done%0d", ch), 64'(done_cnt[ch]), 64'(target));
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        repeat (2) tick();
        HRESET = 1'b0;
        exp_q.delete();
        tick();
    endtask

    initial begin
        int t0, t1, snap, n;
        logic seen;

        // Reset values.
        repeat (3) tick();
        check("rst_htrans", 64'(bus.HTRANS), 64'(HTRANS_IDLE));
        check("rst_haddr", 64'(bus.HADDR), 64'h0);
        check("rst_hwrite", 64'(bus.HWRITE), 64'h0);
        check("rst_hsize", 64'(bus.HSIZE), 64'(HSIZE_WORD));
        check("rst_hwdata", 64'(bus.HWDATA), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        HRESET = 1'b0;
        tick();

        // Two blocks of four word beats on channel 0.
        cfg(0, 32'h100, 32'h200, 3'd2, 3'd2, 3'd4, 3'd4, 4, 2, 1'b0, 3'd0);
        push_block(0, 4);
        push_block(0, 4);
        t0 = done_cnt[0] + 1;
        pulse_start(4'b0001);
        check("busy_after_start", 64'(busy[0]), 64'h1);
        wait_done(0, t0, 400);
        repeat (4) tick();
        check("done0_single", 64'(done_cnt[0]), 64'(t0));
        check("q_empty_t1", 64'(exp_q.size()), 64'h0);
        check("busy_idle_t1", 64'(busy), 64'h0);

        // Simultaneous start on ch0/ch1 interleaves per block; a restart while busy is ignored.
        do_reset();
        cfg(0, 32'h1000, 32'h2000, 3'd2, 3'd2, 3'd4, 3'd4, 2, 2, 1'b0, 3'd0);
        cfg(1, 32'h3000, 32'h4000, 3'd2, 3'd2, 3'd4, 3'd4, 2, 2, 1'b0, 3'd0);
        push_block(0, 2);
        push_block(1, 2);
        push_block(0, 2);
        push_block(1, 2);
        t0 = done_cnt[0] + 1;
        t1 = done_cnt[1] + 1;
        pulse_start(4'b0011);
        saddr[31:0] = 32'hDEAD_0000;
        tick();
        pulse_start(4'b0001);
        wait_done(0, t0, 400);
        wait_done(1, t1, 400);
        repeat (2) tick();
        check("q_empty_t2", 64'(exp_q.size()), 64'h0);
        check("busy_idle_t2", 64'(busy), 64'h0);

        // Byte source at 0x103: lane 3 replicated.
        cfg(2, 32'h103, 32'h500, 3'd0, 3'd0, 3'd1, 3'd1, 2, 1, 1'b0, 3'd0);
        push_block(2, 2);
        t0 = done_cnt[2] + 1;
        pulse_start(4'b0100);
        wait_done(2, t0, 200);
        check("q_empty_t3", 64'(exp_q.size()), 64'h0);

        // Peripheral-request gating on pirq[3].
        cfg(3, 32'h600, 32'h700, 3'd2, 3'd2, 3'd4, 3'd4, 1, 1, 1'b1, 3'd3);
        push_block(3, 1);
        t0 = done_cnt[3] + 1;
        snap = act_cnt;
        pulse_start(4'b1000);
        repeat (20) tick();
        check("no_bus_before_pirq", 64'(act_cnt), 64'(snap));
        check("busy_while_waiting", 64'(busy[3]), 64'h1);
        pirq = 8'h08;
        wait_done(3, t0, 200);
        pirq = 8'h00;
        check("q_empty_t4", 64'(exp_q.size()), 64'h0);

        // Wait states in RD_D and WR_A.
        stall_en = 1'b1;
        snap = stall_hits;
        cfg(1, 32'h800, 32'h900, 3'd2, 3'd2, 3'd4, 3'd4, 2, 1, 1'b0, 3'd0);
        push_block(1, 2);
        t0 = done_cnt[1] + 1;
        pulse_start(4'b0010);
        wait_done(1, t0, 300);
        stall_en = 1'b0;
        check("stall_events", 64'(stall_hits - snap), 64'd4);
        check("q_empty_t5", 64'(exp_q.size()), 64'h0);

        // Zero-length transfers: done one cycle after latch, never busy, no bus traffic.
        cfg(0, 32'hA00, 32'hB00, 3'd2, 3'd2, 3'd4, 3'd4, 4, 0, 1'b0, 3'd0);
        cfg(1, 32'hA40, 32'hB40, 3'd2, 3'd2, 3'd4, 3'd4, 0, 3, 1'b0, 3'd0);
        snap = act_cnt;
        start = 4'b0011;
        tick();
        check("zero_done", 64'(done[1:0]), 64'h3);
        check("zero_busy", 64'(busy[1:0]), 64'h0);
        start = '0;
        tick();
        check("zero_done_end", 64'(done[1:0]), 64'h0);
        repeat (10) tick();
        check("zero_no_bus", 64'(act_cnt), 64'(snap));

        // Reset in the middle of a write data phase, then a fresh transfer.
        cfg(0, 32'hC00, 32'hD00, 3'd2, 3'd2, 3'd4, 3'd4, 4, 4, 1'b0, 3'd0);
        for (int b = 0; b < 4; b++) push_block(0, 4);
        pulse_start(4'b0001);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            tick();
            seen = wr_d_seen;
            n++;
        end
        check("reached_wr_d", 64'(seen), 64'h1);
        HRESET = 1'b1;
        tick();
        check("abort_htrans", 64'(bus.HTRANS), 64'(HTRANS_IDLE));
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_hwdata", 64'(bus.HWDATA), 64'h0);
        HRESET = 1'b0;
        exp_q.delete();
        tick();
        cfg(0, 32'hE00, 32'hF00, 3'd2, 3'd2, 3'd4, 3'd4, 1, 1, 1'b0, 3'd0);
        push_block(0, 1);
        t0 = done_cnt[0] + 1;
        pulse_start(4'b0001);
        wait_done(0, t0, 200);
        check("q_empty_t7", 64'(exp_q.size()), 64'h0);
        check("busy_idle_end", 64'(busy), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
